// File: rtl/dma_fetch_ctrl_pkg.sv
// dma_fetch_ctrl_pkg: shared ring-buffer constants, fetch state encoding and FIFO entry layout
package dma_fetch_ctrl_pkg;
  localparam int PDU_DEPTH     = 512;
  localparam int PDU_AWIDTH    = $clog2(PDU_DEPTH);
  localparam int THRESHOLD     = 64;
  localparam int MAX_SLOT      = PDU_DEPTH - THRESHOLD;
  localparam int APP_IDX_WIDTH = 4;
  localparam int FLIT_W        = 512;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} fetch_state_t;

  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [APP_IDX_WIDTH-1:0] queue;
    logic [FLIT_W-1:0]        data;
  } fifo_entry_t;

  typedef struct packed {
    logic                     vld;
    logic                     sop;
    logic                     eop;
    logic [APP_IDX_WIDTH-1:0] queue;
  } rd_tag_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/dma_fetch_ctrl_fifo.sv
// dma_fetch_fifo: show-ahead synchronous FIFO holding fetched flits with occupancy output
import dma_fetch_ctrl_pkg::*;
module dma_fetch_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_push,
  input  fifo_entry_t                       i_din,
  input  logic                              i_pop,
  output fifo_entry_t                       o_head,
  output logic                              o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_occ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fifo_entry_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_cnt;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset since the head is only consumed when non-empty
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr_ptr] <= i_din;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= bump(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= bump(r_rd_ptr);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_cnt == '0);
  assign o_occ   = r_cnt;
endmodule

// File: rtl/dma_fetch_ctrl.sv
// dma_fetch_ctrl: fetches a DMA's flits from the ring buffer into a stream; DMA_FETCH_STATS_EN enables statistics
import dma_fetch_ctrl_pkg::*;
module dma_fetch_ctrl #(
  parameter int PDU_DEPTH  = dma_fetch_ctrl_pkg::PDU_DEPTH,
  parameter int PDU_AWIDTH = $clog2(PDU_DEPTH),
  parameter int THRESHOLD  = dma_fetch_ctrl_pkg::THRESHOLD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dma_start,
  input  logic [PDU_AWIDTH-1:0]    dma_size,
  input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
  input  logic [APP_IDX_WIDTH-1:0] dma_queue,
  output logic                     dma_done,
  output logic [PDU_AWIDTH-1:0]    rd_addr,
  output logic                     rd_en,
  input  logic                     rd_valid,
  input  logic [FLIT_W-1:0]        rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [APP_IDX_WIDTH-1:0] out_queue,
  output logic [31:0]              stat_dma_cnt,
  output logic [31:0]              stat_flit_cnt,
  output logic [31:0]              stat_stall_cnt
);
  localparam int MAX_SLOT = PDU_DEPTH - THRESHOLD;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);

  fetch_state_t              r_state;
  logic [PDU_AWIDTH-1:0]     r_cur_addr, r_remaining;
  logic [APP_IDX_WIDTH-1:0]  r_queue;
  logic                      r_first, r_zero, r_zero_dly;
  rd_tag_t [2:0]             r_tag;
  logic [CW-1:0]             w_occ;
  logic                      w_empty, w_pop, w_push, w_issue;
  fifo_entry_t               w_head, w_din;
  logic [31:0]               w_used;
  logic [PDU_AWIDTH-1:0]     w_next_addr;

  assign w_pop       = out_valid & out_ready;
  assign w_push      = rd_valid & r_tag[2].vld;
  assign w_din       = '{sop: r_tag[2].sop, eop: r_tag[2].eop, queue: r_tag[2].queue, data: rd_data};
  // Slots committed after this edge: in-flight reads plus stored flits, less the one leaving now
  assign w_used      = 32'(r_tag[0].vld) + 32'(r_tag[1].vld) + 32'(r_tag[2].vld) + 32'(w_occ) - 32'(w_pop);
  assign w_issue     = (r_state == ST_READ) && (w_used < 32'(FIFO_DEPTH));
  assign w_next_addr = (32'(r_cur_addr) + 32'd1 >= 32'(MAX_SLOT)) ? '0 : r_cur_addr + 1'b1;

  // Fetch sequencer: accepts descriptors, issues credit-limited reads, signals completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_queue     <= '0;
      r_first     <= 1'b0;
      r_zero      <= 1'b0;
      r_zero_dly  <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      dma_done    <= 1'b0;
    end else begin
      rd_en    <= w_issue;
      dma_done <= 1'b0;
      if (w_issue) begin
        rd_addr     <= r_cur_addr;
        r_cur_addr  <= w_next_addr;
        r_remaining <= r_remaining - 1'b1;
        r_first     <= 1'b0;
      end
      case (r_state)
        ST_IDLE:
          if (dma_start) begin
            r_cur_addr  <= dma_base_addr;
            r_remaining <= dma_size;
            r_queue     <= dma_queue;
            r_first     <= 1'b1;
            r_zero      <= (dma_size == '0);
            r_zero_dly  <= 1'b0;
            r_state     <= (dma_size == '0) ? ST_DRAIN : ST_READ;
          end
        ST_READ:
          if (w_issue && r_remaining == PDU_AWIDTH'(1)) r_state <= ST_DRAIN;
        ST_DRAIN:
          if (r_zero ? r_zero_dly : (w_pop && w_head.eop)) begin
            dma_done <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_zero_dly <= r_zero;
          end
        default: r_state <= ST_IDLE;
      endcase
    end

  // Read tag pipeline: tracks the fixed 2-cycle read latency so returning flits get sop/eop/queue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tag <= '0;
    else r_tag <= {r_tag[1:0], w_issue ? rd_tag_t'{vld: 1'b1, sop: r_first, eop: (r_remaining == PDU_AWIDTH'(1)), queue: r_queue} : rd_tag_t'('0)};

  dma_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head.data;
  assign out_sop   = !w_empty && w_head.sop;
  assign out_eop   = !w_empty && w_head.eop;
  assign out_queue = w_empty ? '0 : w_head.queue;

`ifdef DMA_FETCH_STATS_EN
  // Saturating event counters for completed DMAs, delivered flits and backpressure cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_dma_cnt   <= '0;
      stat_flit_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      stat_dma_cnt   <= sat_inc(stat_dma_cnt, dma_done);
      stat_flit_cnt  <= sat_inc(stat_flit_cnt, w_pop);
      stat_stall_cnt <= sat_inc(stat_stall_cnt, out_valid & !out_ready);
    end
`else
  assign stat_dma_cnt   = '0;
  assign stat_flit_cnt  = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: doc/dma_fetch_ctrl.md
DMA_FETCH_CTRL -- requirements
Module: dma_fetch_ctrl

Interface
REQ-001 Parameter PDU_DEPTH, 512, ring buffer depth in flits.
REQ-002 Parameter PDU_AWIDTH, $clog2(PDU_DEPTH), flit address width.
REQ-003 Parameter THRESHOLD, 64, ring buffer guard band; MAX_SLOT = PDU_DEPTH - THRESHOLD.
REQ-004 Parameter FIFO_DEPTH, 4, output FIFO entries; must be >= 4 (covers 2-cycle read latency).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 dma_start  in  1  one-cycle pulse: new DMA descriptor valid.
REQ-008 dma_size  in  PDU_AWIDTH  DMA length in flits.
REQ-009 dma_base_addr  in  PDU_AWIDTH  first flit address.
REQ-010 dma_queue  in  APP_IDX_WIDTH  destination queue id.
REQ-011 dma_done  out  1  one-cycle pulse: DMA fully delivered.
REQ-012 rd_addr  out  PDU_AWIDTH  ring buffer read address.
REQ-013 rd_en  out  1  ring buffer read strobe.
REQ-014 rd_valid  in  1  read data valid, exactly 2 cycles after rd_en.
REQ-015 rd_data  in  512  read flit.
REQ-016 out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-017 out_data  out  512  flit payload.
REQ-018 out_sop / out_eop  out  1 / 1  first / last flit of DMA.
REQ-019 out_queue  out  APP_IDX_WIDTH  queue id of current flit.
REQ-020 stat_dma_cnt, stat_flit_cnt, stat_stall_cnt  out  32 each  statistics.

Function
REQ-021 States IDLE, READ, DRAIN; IDLE latches base, size, queue on dma_start and goes READ (size > 0) or DRAIN (size == 0).
REQ-022 READ issues rd_en with rd_addr = cur_addr only when outstanding reads + FIFO occupancy < FIFO_DEPTH; never overflows the FIFO.
REQ-023 Address advance: cur_addr + 1 >= MAX_SLOT wraps to 0, else cur_addr + 1 (identical to ring buffer head rule).
REQ-024 Remaining counter decrements per issued read; READ -> DRAIN in the cycle the last read issues.
REQ-025 Each rd_valid pushes {rd_data, sop, eop, queue} into the FIFO; sop on first flit, eop on last flit; size 1 sets both.
REQ-026 DRAIN -> IDLE when FIFO empty and no reads outstanding; dma_done pulses exactly one cycle in the cycle after the eop handshake (out_valid & out_ready & out_eop).
REQ-027 size == 0: no reads, no output flits; dma_done pulses 3 cycles after dma_start.
REQ-028 dma_done never fires earlier than 3 cycles after its dma_start.
REQ-029 dma_start outside IDLE is ignored; no state change.
REQ-030 out_* held stable while out_valid & !out_ready; output is FIFO head, zero-bubble at full throughput (1 flit/cycle when out_ready constantly high, after 3-cycle initial latency).
REQ-031 Statistics saturate at 2^32-1: dma_cnt per dma_done, flit_cnt per output handshake, stall_cnt per cycle of out_valid & !out_ready.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, rd_en 0, rd_addr 0, dma_done 0, out_valid 0, out_sop 0, out_eop 0, out_queue 0, out_data 0, FIFO empty, outstanding 0, stats 0.
REQ-033 Reset mid-DMA discards in-flight reads; rd_valid arriving after reset release is dropped until a new dma_start.

Configuration
REQ-034 Macro DMA_FETCH_STATS_EN: defined -> stat_* counters implemented per REQ-031; undefined -> counters not synthesised, stat_* ports tied to 0.

Structure
REQ-035 Shared package holds PDU_DEPTH, PDU_AWIDTH, THRESHOLD, MAX_SLOT, APP_IDX_WIDTH, fetch state enum, and FIFO entry struct {sop, eop, queue, data}.
REQ-036 One sub-module dma_fetch_fifo: synchronous FIFO, FIFO_DEPTH entries, show-ahead, occupancy output, async active-low reset.

Verification
REQ-037 dma_start base 10, size 4, queue 3, out_ready=1 -> rd_addr 10,11,12,13; four flits, sop on first, eop on last, out_queue 3; one dma_done.
REQ-038 base 446, size 4 (MAX_SLOT 448) -> rd_addr 446,447,0,1; data order preserved.
REQ-039 size 16, out_ready toggling 1-cycle on/off -> no FIFO overflow, occupancy <= 4, all 16 flits in order, stall_cnt = low cycles with out_valid (STATS_EN).
REQ-040 size 0 -> no rd_en, no out_valid; dma_done exactly 3 cycles after dma_start; second dma_start during READ ignored.
REQ-041 rst_n low during flit 2 of size 8 -> all outputs at reset values immediately; late rd_valid dropped; next DMA base 0, size 2 delivers cleanly.
